// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Bundles the requester handshake and the ALU command/result signals used
//   by alu_mul_sequencer.
//   Parameter N : operand/product width (must match the ALU).
//   Requester side : start, a, b -> busy, done, product, ovf
//   ALU side       : alu_op1, alu_op2, alu_cmd -> alu_out, alu_over
//   Modports: slave  = the sequencer itself
//             master = requester plus ALU (whoever surrounds the sequencer)
interface alu_mul_sequencer_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic         ovf;
    logic [N-1:0] alu_op1;
    logic [N-1:0] alu_op2;
    logic [3:0]   alu_cmd;
    logic [N-1:0] alu_out;
    logic         alu_over;

    modport slave (
        input  start, a, b, alu_out, alu_over,
        output busy, done, product, ovf, alu_op1, alu_op2, alu_cmd
    );

    modport master (
        output start, a, b, alu_out, alu_over,
        input  busy, done, product, ovf, alu_op1, alu_op2, alu_cmd
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Shift-and-add multiplier controller that time-shares one external
//   combinational ALU. Computes product = a*b truncated to N bits, with an
//   overflow flag that is set when the true product needs more than N bits.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; aborts any operation in flight
//   bus  : alu_mul_sequencer_if.slave
//          start/a/b in, busy/done/product/ovf out (requester side)
//          alu_op1/alu_op2/alu_cmd out, alu_out/alu_over in (ALU side)
// Build option
//   MUL_EARLY_EXIT_EN : when defined, the loop ends as soon as no multiplier
//   bits remain, so latency depends on the position of b's highest set bit.
//   Results are identical to the default fixed-latency build.
module alu_mul_sequencer #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_mul_sequencer_if.slave    bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SHL = 4'd2;

    typedef enum logic [1:0] {IDLE, ADD, SHL, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  acc;
    logic [N-1:0]  ma;
    logic [N-1:0]  mb;
    logic [IW-1:0] iter;
    logic          ovf_int;
    logic [N-1:0]  product_r;
    logic          ovf_r;

    logic          busy_w;
    logic          done_w;
    logic [N-1:0]  op1_w;
    logic [N-1:0]  op2_w;
    logic [3:0]    cmd_w;
    logic          shl_last;
    logic          ovf_shl;

    // Shifting a set MSB out of ma only loses product bits if some higher
    // multiplier bit is still going to add the shifted value in later.
    assign ovf_shl = ovf_int | (ma[N-1] & ((mb >> 1) != '0));

`ifdef MUL_EARLY_EXIT_EN
    assign shl_last = (iter == IW'(N - 1)) || ((mb >> 1) == '0);
`else
    assign shl_last = (iter == IW'(N - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_w    = 1'b0;
        done_w    = 1'b0;
        op1_w     = '0;
        op2_w     = '0;
        cmd_w     = CMD_ADD;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = ADD;
            end
            ADD: begin
                busy_w    = 1'b1;
                cmd_w     = CMD_ADD;
                op1_w     = acc;
                op2_w     = ma;
                state_nxt = SHL;
            end
            SHL: begin
                busy_w    = 1'b1;
                cmd_w     = CMD_SHL;
                op1_w     = ma;
                op2_w     = N'(1);
                state_nxt = shl_last ? DONE : ADD;
            end
            DONE: begin
                done_w    = 1'b1;
                state_nxt = bus.start ? ADD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
            iter      <= '0;
            ovf_int   <= 1'b0;
            product_r <= '0;
            ovf_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        ma      <= bus.a;
                        mb      <= bus.b;
                        acc     <= '0;
                        ovf_int <= 1'b0;
                        iter    <= '0;
                    end
                end
                ADD: begin
                    // Skipped additions still burn the cycle so timing is
                    // independent of the multiplier's bit pattern.
                    if (mb[0]) begin
                        acc     <= bus.alu_out;
                        ovf_int <= ovf_int | bus.alu_over;
                    end
                end
                SHL: begin
                    ma      <= bus.alu_out;
                    mb      <= mb >> 1;
                    iter    <= iter + 1'b1;
                    ovf_int <= ovf_shl;
                    if (shl_last) begin
                        product_r <= acc;
                        ovf_r     <= ovf_shl;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_w;
    assign bus.done    = done_w;
    assign bus.product = product_r;
    assign bus.ovf     = ovf_r;
    assign bus.alu_op1 = op1_w;
    assign bus.alu_op2 = op2_w;
    assign bus.alu_cmd = cmd_w;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
//   Testbench for alu_mul_sequencer with N=8. Provides a behavioural ALU
//   (cmd 0 = add with carry-out, cmd 2 = shift left), drives a table of
//   multiply vectors and a few hand-written multi-cycle sequences.
//   Latency expectations follow MUL_EARLY_EXIT_EN when it is defined.
module tb_alu_mul_sequencer;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    alu_mul_sequencer_if #(.N(N)) bus ();

    alu_mul_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    logic [N:0]     alu_sum;
    logic [2*N-1:0] alu_wide;
    always_comb begin
        alu_sum  = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
        alu_wide = {{N{1'b0}}, bus.alu_op1} << bus.alu_op2;
        if (bus.alu_cmd == 4'd2) begin
            bus.alu_out  = alu_wide[N-1:0];
            bus.alu_over = |alu_wide[2*N-1:N];
        end else if (bus.alu_cmd == 4'd0) begin
            bus.alu_out  = alu_sum[N-1:0];
            bus.alu_over = alu_sum[N];
        end else begin
            bus.alu_out  = '0;
            bus.alu_over = 1'b0;
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int k = 1;
        for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
        return 2 * k + 1;
`else
        return 2 * N + 1;
`endif
    endfunction

`ifdef MUL_EARLY_EXIT_EN
    localparam int PULSE_CYC = 3;
`else
    localparam int PULSE_CYC = 5;
`endif

    logic [3:0]   cmd_tr [8];
    logic [N-1:0] op1_tr [8];
    logic [N-1:0] op2_tr [8];

    // Issues one operation from IDLE or DONE. Sampling index 1 is the cycle
    // right after the accepting edge; lat is the index where done is seen
    // (0 if it never appears within the bound).
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output int busy_cyc,
                         output logic [N-1:0] prod, output logic ov);
        int nt;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 8'hA5;
        bus.b     = 8'h5A;
        lat = 0; busy_cyc = 0; nt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_cyc++;
            if (nt < 8) begin
                cmd_tr[nt] = bus.alu_cmd;
                op1_tr[nt] = bus.alu_op1;
                op2_tr[nt] = bus.alu_op2;
                nt++;
            end
            @(posedge clk); #1;
        end
        prod = bus.product;
        ov   = bus.ovf;
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] prod;
        logic         ovf;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat, bc, cnt;
        logic [N-1:0] p;
        logic o;

        vecs[0]  = '{8'd8,   8'd3,   8'd24,  1'b0};
        vecs[1]  = '{8'd16,  8'd16,  8'd0,   1'b1};
        vecs[2]  = '{8'd200, 8'd2,   8'd144, 1'b1};
        vecs[3]  = '{8'd255, 8'd1,   8'd255, 1'b0};
        vecs[4]  = '{8'd255, 8'd2,   8'd254, 1'b1};
        vecs[5]  = '{8'd0,   8'd77,  8'd0,   1'b0};
        vecs[6]  = '{8'd77,  8'd0,   8'd0,   1'b0};
        vecs[7]  = '{8'd15,  8'd17,  8'd255, 1'b0};
        vecs[8]  = '{8'd16,  8'd17,  8'd16,  1'b1};
        vecs[9]  = '{8'd100, 8'd3,   8'd44,  1'b1};
        vecs[10] = '{8'd1,   8'd255, 8'd255, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset busy",    int'(bus.busy),    0);
        check("reset done",    int'(bus.done),    0);
        check("reset product", int'(bus.product), 0);
        check("reset ovf",     int'(bus.ovf),     0);
        check("reset alu_op1", int'(bus.alu_op1), 0);

        for (int v = 0; v < 11; v++) begin
            do_op(vecs[v].a, vecs[v].b, lat, bc, p, o);
            check($sformatf("vec%0d latency", v), lat, exp_lat(vecs[v].b));
            check($sformatf("vec%0d busy cycles", v), bc, exp_lat(vecs[v].b) - 1);
            check($sformatf("vec%0d product", v), int'(p), int'(vecs[v].prod));
            check($sformatf("vec%0d ovf", v), int'(o), int'(vecs[v].ovf));
            @(posedge clk); #1;
            check($sformatf("vec%0d done pulse width", v), int'(bus.done), 0);
            check($sformatf("vec%0d product held", v), int'(bus.product), int'(vecs[v].prod));
        end

        // ALU command/operand trace for 5*3
        do_op(8'd5, 8'd3, lat, bc, p, o);
        check("5x3 latency", lat, exp_lat(8'd3));
        check("5x3 product", int'(p), 15);
        check("trace cmd0", int'(cmd_tr[0]), 0);
        check("trace cmd1", int'(cmd_tr[1]), 2);
        check("trace cmd2", int'(cmd_tr[2]), 0);
        check("trace cmd3", int'(cmd_tr[3]), 2);
        check("trace add op2", int'(op2_tr[0]), 5);
        check("trace shl op1", int'(op1_tr[1]), 5);
        check("trace shl op2", int'(op2_tr[1]), 1);
        check("trace add2 op1", int'(op1_tr[2]), 5);
        check("trace add2 op2", int'(op2_tr[2]), 10);
        @(posedge clk); #1;

        // start pulsed mid-operation must be ignored
        bus.start = 1'b1;
        bus.a = 8'd8;
        bus.b = 8'd3;
        @(posedge clk); #1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            bus.start = (i == PULSE_CYC);
            bus.a = 8'd1;
            bus.b = 8'd1;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("ignored start latency", lat, exp_lat(8'd3));
        check("ignored start product", int'(bus.product), 24);
        check("ignored start ovf", int'(bus.ovf), 0);

        // start held in the DONE cycle chains the next op with no gap
        do_op(8'd2, 8'd2, lat, bc, p, o);
        check("chained latency", lat, exp_lat(8'd2));
        check("chained busy cycles", bc, exp_lat(8'd2) - 1);
        check("chained product", int'(p), 4);
        check("chained ovf", int'(o), 0);

        // reset in the middle of an operation
        bus.start = 1'b1;
        bus.a = 8'd8;
        bus.b = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("pre-abort busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        check("abort product", int'(bus.product), 0);
        check("abort alu_cmd", int'(bus.alu_cmd), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done || bus.busy) cnt++;
            @(posedge clk); #1;
        end
        check("abort no done", cnt, 0);
        do_op(8'd8, 8'd3, lat, bc, p, o);
        check("post-abort latency", lat, exp_lat(8'd3));
        check("post-abort product", int'(p), 24);
        check("post-abort ovf", int'(o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
